// File: rtl/game_io_bridge.sv
// game_io_bridge
//   Memory-mapped bridge between the processor data-memory port and the board
//   game controls. Each input channel is synchronised, debounced and
//   edge-latched into a press flag. Software reads STATE, PRESS and MASK, and
//   reads and writes the OUT registers, using ordinary loads and stores.
//
//   Word map relative to ADDR_BASE:
//     +0 STATE  stable levels, read-only
//     +1 PRESS  press flags, write-1-to-clear
//     +2 MASK   event mask, read/write
//     +3 reserved, reads 0
//     +4.. OUT[k], 32-bit read/write
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-high
//   btn_in        raw asynchronous control inputs
//   address_dmem  processor data word address
//   data          processor store data
//   wren          processor store enable
//   io_sel        address_dmem is inside the window (combinational)
//   io_sel_q      io_sel registered, qualifies q_io
//   q_io          registered read data (1-cycle latency)
//   out_regs      packed OUT registers, OUT[k] at [32k+31:32k]
//   event_pending registered OR of (PRESS & MASK)
module game_io_bridge #(
  parameter int unsigned NUM_IN          = 8,
  parameter int unsigned NUM_OUT         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [11:0] ADDR_BASE       = 12'hF00
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_IN-1:0]      btn_in,
  input  logic [11:0]            address_dmem,
  input  logic [31:0]            data,
  input  logic                   wren,
  output logic                   io_sel,
  output logic                   io_sel_q,
  output logic [31:0]            q_io,
  output logic [NUM_OUT*32-1:0]  out_regs,
  output logic                   event_pending
);

  localparam int unsigned CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0] WIN_SIZE   = 12'(4 + NUM_OUT);
  localparam logic [11:0] OFF_STATE  = 12'd0;
  localparam logic [11:0] OFF_PRESS  = 12'd1;
  localparam logic [11:0] OFF_MASK   = 12'd2;
  localparam logic [11:0] OFF_OUT0   = 12'd4;

  // Address decode
  logic [11:0] offset;
  logic        in_window;
  logic        wr_en;

  // Input path state
  logic [NUM_IN-1:0] sync1;
  logic [NUM_IN-1:0] sync2;
  logic [NUM_IN-1:0] stable;
  logic [NUM_IN-1:0] stable_nxt;
  logic [CW-1:0]     cnt     [NUM_IN];
  logic [CW-1:0]     cnt_nxt [NUM_IN];

  // Software-visible registers
  logic [NUM_IN-1:0] press;
  logic [NUM_IN-1:0] press_nxt;
  logic [NUM_IN-1:0] press_clr;
  logic [NUM_IN-1:0] mask;
  logic [31:0]       out_r [NUM_OUT];
  logic [31:0]       rd_data;

  // The window never wraps past 12'hFFF, so an address below the base gives
  // an offset of at least 4096-ADDR_BASE, which is already outside the window.
  assign offset    = address_dmem - ADDR_BASE;
  assign in_window = (address_dmem >= ADDR_BASE) && (offset < WIN_SIZE);
  assign io_sel    = in_window & ~reset;
  assign wr_en     = wren & in_window;

  // Debounce: the counter runs only while sync disagrees with stable and
  // restarts whenever they agree, so only an unbroken run of DEBOUNCE_CYCLES
  // differing samples moves stable.
  always_comb begin
    stable_nxt = stable;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // A rising edge of stable landing on the same edge as a W1C store keeps
  // the flag set: the set term is ORed in after the clear.
  always_comb begin
    press_clr = '0;
    if (wr_en && (offset == OFF_PRESS)) begin
      press_clr = data[NUM_IN-1:0];
    end
    press_nxt = (press & ~press_clr) | (stable_nxt & ~stable);
  end

  // Read mux works from current (pre-write) state, so a read and write to
  // the same address in one cycle returns the old value.
  always_comb begin
    rd_data = '0;
    if (in_window) begin
      if (offset == OFF_STATE) begin
        rd_data[NUM_IN-1:0] = stable;
      end else if (offset == OFF_PRESS) begin
        rd_data[NUM_IN-1:0] = press;
      end else if (offset == OFF_MASK) begin
        rd_data[NUM_IN-1:0] = mask;
      end
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (offset == OFF_OUT0 + 12'(k)) begin
          rd_data = out_r[k];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      stable        <= '0;
      press         <= '0;
      mask          <= '0;
      q_io          <= '0;
      io_sel_q      <= 1'b0;
      event_pending <= 1'b0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        cnt[i] <= '0;
      end
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        out_r[k] <= '0;
      end
    end else begin
      sync1         <= btn_in;
      sync2         <= sync1;
      stable        <= stable_nxt;
      press         <= press_nxt;
      q_io          <= rd_data;
      io_sel_q      <= in_window;
      event_pending <= |(press & mask);
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (wr_en && (offset == OFF_MASK)) begin
        mask <= data[NUM_IN-1:0];
      end
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (wr_en && (offset == OFF_OUT0 + 12'(k))) begin
          out_r[k] <= data;
        end
      end
    end
  end

  always_comb begin
    out_regs = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      out_regs[32*k +: 32] = out_r[k];
    end
  end

endmodule
